// File: rtl/keystone_config_ctrl.sv
// keystone_config_ctrl
//   Frame-synchronous configuration and sequencing controller for the
//   Keystone_Correction core. Coefficient writes are staged in a shadow
//   register and swapped into the active set only on a frame-start beat,
//   so a frame never sees a mix of old and new homography values. The
//   core clock enable is opened/closed only at frame starts, and
//   software reset requests are stretched into a fixed-length core reset.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   cfg_coeffs            shadow source {H32,H31,H23,H22,H21,H13,H12,H11}
//   cfg_commit            strobe: capture cfg_coeffs into shadow, mark pending
//   cfg_enable            level request to run the core
//   cfg_sw_reset          strobe: request a core reset pulse
//   s_valid/s_ready/
//   s_tuser/s_tlast       observed input-stream handshake (never driven)
//   coef_out              coefficients presented to core a..h
//   core_clock_en         core clock enable
//   core_reset            core reset
//   commit_pending        shadow written but not yet applied
//   running               controller is in RUN
//   frame_count           frames started with the core enabled (wraps)
//   line_count            tlast beats in the current frame
//   lines_last_frame      line_count captured at each frame-start beat
//
// State table
//   state     | meaning
//   RST_CORE  | core held in reset, clock enabled so the reset lands
//   IDLE      | core clock gated off
//   WAIT_SOF  | armed, waiting for the next frame-start beat
//   RUN       | core clocked, frames in flight

module keystone_config_ctrl #(
  parameter int DATA_WIDTH         = 32,
  parameter int RESET_PULSE_CYCLES = 4,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [8*DATA_WIDTH-1:0] cfg_coeffs,
  input  logic                    cfg_commit,
  input  logic                    cfg_enable,
  input  logic                    cfg_sw_reset,
  input  logic                    s_valid,
  input  logic                    s_ready,
  input  logic                    s_tuser,
  input  logic                    s_tlast,
  output logic [8*DATA_WIDTH-1:0] coef_out,
  output logic                    core_clock_en,
  output logic                    core_reset,
  output logic                    commit_pending,
  output logic                    running,
  output logic [CNT_WIDTH-1:0]    frame_count,
  output logic [CNT_WIDTH-1:0]    line_count,
  output logic [CNT_WIDTH-1:0]    lines_last_frame
);

  localparam int RCW = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_RELOAD = RCW'(RESET_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST_CORE = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_SOF = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [RCW-1:0]          r_rst_cnt;
  logic [RCW-1:0]          w_rst_cnt_nxt;

  logic [8*DATA_WIDTH-1:0] r_active;
  logic [8*DATA_WIDTH-1:0] r_shadow;
  logic                    r_pending;

  logic [CNT_WIDTH-1:0]    r_frame_count;
  logic [CNT_WIDTH-1:0]    r_line_count;
  logic [CNT_WIDTH-1:0]    r_lines_last;

  logic                    w_beat;
  logic                    w_sof_beat;
  logic                    w_eol_beat;
  logic                    w_clock_en;
  logic                    w_apply;

  assign w_beat     = s_valid & s_ready;
  assign w_sof_beat = w_beat & s_tuser;
  assign w_eol_beat = w_beat & s_tlast;

  // The frame-start beat that opens a frame is clocked into the core; the
  // frame-start beat that closes running (enable dropped) is not.
  assign w_clock_en = ((r_state == ST_RUN) & ~(w_sof_beat & ~cfg_enable)) |
                      ((r_state == ST_WAIT_SOF) & w_sof_beat) |
                      (r_state == ST_RST_CORE);

  // The clock enable is forced high in RST_CORE only so the core's reset
  // takes effect; beats seen there must not swap coefficients.
  assign w_apply = r_pending & w_sof_beat & w_clock_en & (r_state != ST_RST_CORE);

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    case (r_state)
      ST_RST_CORE: begin
        if (r_rst_cnt == '0) w_state_nxt = ST_IDLE;
        else                 w_rst_cnt_nxt = r_rst_cnt - RCW'(1);
      end
      ST_IDLE: begin
        if (cfg_enable) w_state_nxt = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (!cfg_enable)     w_state_nxt = ST_IDLE;
        else if (w_sof_beat) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_sof_beat && !cfg_enable) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_RST_CORE;
    endcase
    if (cfg_sw_reset) begin
      w_state_nxt   = ST_RST_CORE;
      w_rst_cnt_nxt = RST_RELOAD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_RST_CORE;
      r_rst_cnt <= RST_RELOAD;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
    end
  end

  // A commit coincident with an apply: the apply consumes the old shadow
  // while the new value lands in shadow and stays pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_apply)    r_active <= r_shadow;
      if (cfg_commit) r_shadow <= cfg_coeffs;
      if (cfg_commit)   r_pending <= 1'b1;
      else if (w_apply) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_frame_count <= '0;
      r_line_count  <= '0;
      r_lines_last  <= '0;
    end else begin
      if (w_sof_beat) begin
        r_lines_last <= r_line_count + CNT_WIDTH'(w_eol_beat);
        r_line_count <= CNT_WIDTH'(w_eol_beat);
      end else if (w_eol_beat) begin
        r_line_count <= r_line_count + CNT_WIDTH'(1);
      end
      if (w_sof_beat && w_clock_en) r_frame_count <= r_frame_count + CNT_WIDTH'(1);
    end
  end

  assign coef_out         = w_apply ? r_shadow : r_active;
  assign core_clock_en    = w_clock_en;
  assign core_reset       = reset | (r_state == ST_RST_CORE);
  assign commit_pending   = r_pending;
  assign running          = (r_state == ST_RUN);
  assign frame_count      = r_frame_count;
  assign line_count       = r_line_count;
  assign lines_last_frame = r_lines_last;

endmodule

// File: tb/tb_keystone_config_ctrl.sv
module tb_keystone_config_ctrl;

  localparam int DW = 32;
  localparam int CW = 16;

  localparam logic [255:0] K0 = 256'h0;
  localparam logic [255:0] K1 = 256'h0001_0000;
  localparam logic [255:0] K2 = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0000_0010, 32'h0, 32'h0001_0000};
  localparam logic [255:0] K3 = {32'h8888_0008, 32'h7777_0007, 32'h6666_0006, 32'h5555_0005,
                                 32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
  localparam logic [255:0] K4 = {32'hDEAD_0008, 32'hBEEF_0007, 32'hCAFE_0006, 32'hF00D_0005,
                                 32'h0BAD_0004, 32'hFACE_0003, 32'h1234_0002, 32'h5678_0001};

  logic                 clock = 1'b0;
  logic                 reset;
  logic [8*DW-1:0]      cfg_coeffs;
  logic                 cfg_commit, cfg_enable, cfg_sw_reset;
  logic                 s_valid, s_ready, s_tuser, s_tlast;
  logic [8*DW-1:0]      coef_out;
  logic                 core_clock_en, core_reset, commit_pending, running;
  logic [CW-1:0]        frame_count, line_count, lines_last_frame;

  keystone_config_ctrl #(.DATA_WIDTH(DW), .RESET_PULSE_CYCLES(4), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .cfg_coeffs(cfg_coeffs), .cfg_commit(cfg_commit),
    .cfg_enable(cfg_enable), .cfg_sw_reset(cfg_sw_reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .coef_out(coef_out), .core_clock_en(core_clock_en), .core_reset(core_reset),
    .commit_pending(commit_pending), .running(running),
    .frame_count(frame_count), .line_count(line_count),
    .lines_last_frame(lines_last_frame)
  );

  always #5 clock = ~clock;

  // bt: 0 no beat, 1 SOF beat, 2 EOL beat, 3 valid+tuser with ready low (not a beat)
  typedef struct {
    logic         rst, en, cm, sw;
    logic [1:0]   bt;
    logic [255:0] cf;
    logic [255:0] e_coef;
    logic         e_cen, e_crst, e_pend, e_run;
    logic [15:0]  e_fc, e_lc, e_llf;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rst, input logic en, input logic cm, input logic sw,
                     input logic [1:0] bt, input logic [255:0] cf,
                     input logic [255:0] ecoef, input logic ecen, input logic ecrst,
                     input logic epend, input logic erun,
                     input int efc, input int elc, input int ellf);
    vec_t v;
    v.rst = rst; v.en = en; v.cm = cm; v.sw = sw; v.bt = bt; v.cf = cf;
    v.e_coef = ecoef; v.e_cen = ecen; v.e_crst = ecrst; v.e_pend = epend; v.e_run = erun;
    v.e_fc = 16'(efc); v.e_lc = 16'(elc); v.e_llf = 16'(ellf);
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [255:0] act,
                     input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic cm, input logic sw,
                       input logic [1:0] bt, input logic [255:0] cf);
    reset = rst; cfg_enable = en; cfg_commit = cm; cfg_sw_reset = sw; cfg_coeffs = cf;
    s_valid = (bt != 2'd0);
    s_ready = (bt == 2'd1) || (bt == 2'd2);
    s_tuser = (bt == 2'd1) || (bt == 2'd3);
    s_tlast = (bt == 2'd2);
  endtask

  initial begin
    int hi;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, K0);

    //   rst en cm sw bt cf    coef cen crst pend run fc lc llf
    add(1, 0, 0, 0, 0, K0,   K0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, K0,   K0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, K0,   K0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, K0,   K0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, K0,   K0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2, K0,   K0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, K1,   K0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 3, K0,   K0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, K0,   K1, 1, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, K0,   K1, 1, 0, 0, 1, 1, 0, 1);
    add(0, 1, 1, 0, 2, K2,   K1, 1, 0, 0, 1, 1, 0, 1);
    add(0, 1, 0, 0, 0, K0,   K1, 1, 0, 1, 1, 1, 1, 1);
    add(0, 1, 0, 0, 1, K0,   K2, 1, 0, 1, 1, 1, 1, 1);
    add(0, 1, 0, 0, 0, K0,   K2, 1, 0, 0, 1, 2, 0, 1);
    add(0, 1, 1, 0, 1, K3,   K2, 1, 0, 0, 1, 2, 0, 1);
    add(0, 1, 0, 0, 0, K0,   K2, 1, 0, 1, 1, 3, 0, 0);
    add(0, 1, 0, 0, 1, K0,   K3, 1, 0, 1, 1, 3, 0, 0);
    add(0, 1, 0, 0, 0, K0,   K3, 1, 0, 0, 1, 4, 0, 0);
    add(0, 1, 1, 0, 0, K4,   K3, 1, 0, 0, 1, 4, 0, 0);
    add(0, 1, 1, 0, 1, K1,   K4, 1, 0, 1, 1, 4, 0, 0);
    add(0, 1, 0, 0, 0, K0,   K4, 1, 0, 1, 1, 5, 0, 0);
    add(0, 0, 0, 0, 0, K0,   K4, 1, 0, 1, 1, 5, 0, 0);
    add(0, 0, 0, 0, 2, K0,   K4, 1, 0, 1, 1, 5, 0, 0);
    add(0, 0, 0, 0, 2, K0,   K4, 1, 0, 1, 1, 5, 1, 0);
    add(0, 0, 0, 0, 2, K0,   K4, 1, 0, 1, 1, 5, 2, 0);
    add(0, 0, 0, 0, 1, K0,   K4, 0, 0, 1, 1, 5, 3, 0);
    add(0, 0, 0, 0, 0, K0,   K4, 0, 0, 1, 0, 5, 0, 3);
    add(0, 1, 0, 0, 0, K0,   K4, 0, 0, 1, 0, 5, 0, 3);
    add(0, 1, 0, 0, 1, K0,   K1, 1, 0, 1, 0, 5, 0, 3);
    add(0, 1, 1, 0, 0, K2,   K1, 1, 0, 0, 1, 6, 0, 0);
    add(0, 1, 0, 1, 0, K0,   K1, 1, 0, 1, 1, 6, 0, 0);
    add(0, 1, 0, 0, 2, K0,   K1, 1, 1, 1, 0, 6, 0, 0);
    add(0, 1, 0, 0, 0, K0,   K1, 1, 1, 1, 0, 6, 1, 0);
    add(0, 1, 0, 0, 0, K0,   K1, 1, 1, 1, 0, 6, 1, 0);
    add(0, 1, 0, 0, 0, K0,   K1, 1, 1, 1, 0, 6, 1, 0);
    add(0, 1, 0, 0, 0, K0,   K1, 0, 0, 1, 0, 6, 1, 0);
    add(0, 1, 0, 0, 1, K0,   K2, 1, 0, 1, 0, 6, 1, 0);
    add(0, 1, 0, 0, 0, K0,   K2, 1, 0, 0, 1, 7, 0, 1);

    foreach (vq[i]) begin
      @(negedge clock);
      drive(vq[i].rst, vq[i].en, vq[i].cm, vq[i].sw, vq[i].bt, vq[i].cf);
      #1;
      chk("coef_out",         i, coef_out,               vq[i].e_coef);
      chk("core_clock_en",    i, 256'(core_clock_en),    256'(vq[i].e_cen));
      chk("core_reset",       i, 256'(core_reset),       256'(vq[i].e_crst));
      chk("commit_pending",   i, 256'(commit_pending),   256'(vq[i].e_pend));
      chk("running",          i, 256'(running),          256'(vq[i].e_run));
      chk("frame_count",      i, 256'(frame_count),      256'(vq[i].e_fc));
      chk("line_count",       i, 256'(line_count),       256'(vq[i].e_lc));
      chk("lines_last_frame", i, 256'(lines_last_frame), 256'(vq[i].e_llf));
    end

    // Software reset pulse from RUN: count core_reset-high cycles (bounded).
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, K0);
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, K0);
    #1;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (core_reset) hi++;
      else break;
      @(negedge clock);
      #1;
    end
    chk("sw_reset_pulse_len", 100, 256'(hi), 256'(4));
    chk("post_swrst_running", 101, 256'(running), 256'(0));
    chk("post_swrst_cen",     102, 256'(core_clock_en), 256'(0));
    chk("post_swrst_coef",    103, coef_out, K2);
    chk("post_swrst_fc",      104, 256'(frame_count), 256'(7));

    // Reset asserted mid-activity: core_reset follows reset combinationally,
    // then everything clears after the first reset edge.
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, K3);
    #1;
    chk("reset_comb_crst", 105, 256'(core_reset), 256'(1));
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, K0);
    #1;
    chk("reset_coef",  106, coef_out, K0);
    chk("reset_pend",  107, 256'(commit_pending), 256'(0));
    chk("reset_run",   108, 256'(running), 256'(0));
    chk("reset_cen",   109, 256'(core_clock_en), 256'(1));
    chk("reset_fc",    110, 256'(frame_count), 256'(0));
    chk("reset_lc",    111, 256'(line_count), 256'(0));
    chk("reset_llf",   112, 256'(lines_last_frame), 256'(0));

    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, K0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keystone_config_ctrl.md
# keystone_config_ctrl

Frame-synchronous configuration and sequencing controller for the Keystone_Correction core. It buffers homography coefficient writes from the AXI-Lite register bank and applies them atomically at a frame boundary, so a frame is never warped with a mix of old and new values. It also gates the core's clock enable only at frame starts and stretches software-reset requests into a fixed-length core reset. It sits between the AXI-Lite register file, the input AXI-Stream handshake, and the core's `clock_en`, `reset` and `a`..`h` inputs.

## Interface
- `DATA_WIDTH`, 32: width of each coefficient.
- `RESET_PULSE_CYCLES`, 4: number of cycles `core_reset` is held after `reset` deasserts or a `cfg_sw_reset` pulse; must be ≥1.
- `CNT_WIDTH`, 16: width of the frame and line counters.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `cfg_coeffs`  in  8*DATA_WIDTH  shadow source, packed {H32,H31,H23,H22,H21,H13,H12,H11}; H11 is in bits [DATA_WIDTH-1:0].
- `cfg_commit`  in  1  one-cycle strobe: capture `cfg_coeffs` into shadow and mark it pending.
- `cfg_enable`  in  1  level request to run the core.
- `cfg_sw_reset`  in  1  one-cycle strobe requesting a core reset.
- `s_valid`, `s_ready`, `s_tuser`, `s_tlast`  in  1 each  monitored input-stream handshake; these are observed only and never driven.
- `coef_out`  out  8*DATA_WIDTH  active coefficients, same packing, to core `a`..`h`.
- `core_clock_en`  out  1  to core `clock_en`.
- `core_reset`  out  1  to core `reset`.
- `commit_pending`  out  1  shadow not yet applied.
- `running`  out  1  state is RUN.
- `frame_count`  out  CNT_WIDTH  frames started with the core enabled; wraps.
- `line_count`  out  CNT_WIDTH  `tlast` beats in the current frame.
- `lines_last_frame`  out  CNT_WIDTH  `line_count` captured at each SOF beat.

## Operation
- Definitions: beat = `s_valid & s_ready`; sof_beat = beat & `s_tuser`; eol_beat = beat & `s_tlast`.
- States:
  - RST_CORE: hold the core in reset; `core_clock_en`=1 so an enable-qualified reset inside the core takes effect.
  - IDLE: `core_clock_en`=0.
  - WAIT_SOF: the core is armed and waiting for the next frame start.
  - RUN: `core_clock_en`=1.
- Transitions:
  - `reset` → RST_CORE, with the counter loaded to RESET_PULSE_CYCLES-1.
  - RST_CORE → IDLE when the counter reaches 0; otherwise decrement.
  - IDLE → WAIT_SOF when `cfg_enable`=1.
  - WAIT_SOF → IDLE when `cfg_enable`=0.
  - WAIT_SOF → RUN on sof_beat.
  - RUN → IDLE on sof_beat with `cfg_enable`=0. Disable therefore takes effect at a frame boundary, never mid-frame.
  - `cfg_sw_reset`=1 in any state → RST_CORE with the counter reloaded. This has priority over every other transition.
- `core_clock_en` = (state==RUN & !(sof_beat & !`cfg_enable`)) | (state==WAIT_SOF & sof_beat) | state==RST_CORE. The SOF beat that starts a frame is clocked into the core; the SOF beat that ends running is not.
- `core_reset` = `reset` | (state==RST_CORE).
- Coefficients:
  - `cfg_commit` captures `cfg_coeffs` into shadow and sets pending. A repeated commit overwrites shadow; pending stays 1.
  - apply = pending & sof_beat & `core_clock_en`. On apply, `coef_out` presents shadow combinationally in that same cycle; active ← shadow; pending clears.
  - At all other times `coef_out` = active.
  - A commit in the same cycle as an apply: the apply uses the previous shadow, the new value is captured, and pending remains 1 for the next frame.
  - A commit coincident with a sof_beat when nothing is pending is not applied to that frame.
  - `cfg_sw_reset` preserves active, shadow and pending.
- Counters:
  - On every sof_beat: `lines_last_frame` ← `line_count` (including an eol on the same beat); `line_count` ← eol_beat?1:0.
  - Otherwise `line_count` increments on eol_beat.
  - `frame_count` increments on sof_beat when `core_clock_en`=1 and wraps modulo 2^CNT_WIDTH.
  - Line counters run in every state.

## Timing
- All registers update on the rising `clock` edge. Sync reset clears active, shadow, pending and all counters to 0, and sets state to RST_CORE.
- Output values while `reset`=1: `coef_out`=0, `core_reset`=1, `core_clock_en`=1, `commit_pending`=0, `running`=0, all counters 0.
- `core_reset` stays high for exactly RESET_PULSE_CYCLES cycles after `reset` falls, and for exactly RESET_PULSE_CYCLES cycles starting the cycle after a `cfg_sw_reset` pulse.
- `commit_pending` rises the cycle after `cfg_commit`.
- State outputs (`running`) follow the transition edge by one cycle. `core_clock_en` and `coef_out` react combinationally to sof_beat.
- Beats arriving in RST_CORE or IDLE do not change state or coefficients but are still counted by the line counters.

## Test plan
- Reset, then 4 idle cycles → `core_reset`=1 for cycles 0..3 after `reset` falls, then 0. State IDLE, `core_clock_en`=0, `coef_out`=0.
- `cfg_enable`=1, commit H11=0x0001_0000, then SOF beat → `coef_out[31:0]`=0x0001_0000 in the SOF cycle, `core_clock_en`=1 on that beat, `frame_count`=1, `commit_pending`=0.
- While RUN, commit H13=0x10 mid-frame → `coef_out` unchanged until the next SOF beat, then H13=0x10 with `frame_count`=2.
- Commit on the exact SOF-beat cycle with nothing pending → `coef_out` unchanged this frame, `commit_pending`=1, applied at the following SOF.
- Drop `cfg_enable` mid-frame, send 3 `tlast` beats then SOF → `core_clock_en` stays 1 until that SOF, which has `core_clock_en`=0. `lines_last_frame`=3, state IDLE, `frame_count` not incremented.
- `cfg_sw_reset` pulse during RUN with a pending commit → `core_reset` high for 4 cycles, then IDLE. Active and pending preserved; pending is applied at the first SOF after re-enabling.
